dvp_stream_tx: RTL and testbench

Transmitter side of the 8-bit parallel camera (DVP) link.
- Turns an internal byte stream (valid/ready) into free-running `camera_pclk_out`, HS/VS framing and 8-bit data.
- Any DVP receiver that samples on PCLK rising edges must accept the output, with pixel valid = HS && VS.
- Sits on the peripheral FPGA between the luminance pipeline and the inter-board connector; also used as a camera emulator in benches.

---
 rtl/dvp_pkg.sv | 26 ++
 rtl/dvp_pclk_gen.sv | 34 +++
 rtl/dvp_stream_tx.sv | 191 +++++++++++++++++++
 tb/tb_dvp_stream_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP transmitter slice.
package dvp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VBLANK,
        ACTIVE,
        HBLANK
    } dvp_state_t;

    localparam int DVP_H_ACTIVE     = 640;
    localparam int DVP_H_BLANK      = 16;
    localparam int DVP_V_ACTIVE     = 480;
    localparam int DVP_V_BLANK      = 10;
    localparam int DVP_CLK_DIV      = 2;
    localparam int DVP_HCOUNT_WIDTH = 11;
    localparam int DVP_VCOUNT_WIDTH = 10;

    localparam logic [7:0] DVP_FILL_BYTE = 8'h00;

    // Width of a counter that must hold 0..count-1, never narrower than one bit.
    function automatic int clog2_min1(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// Free-running PCLK divider: low CLK_DIV cycles, high CLK_DIV cycles, with a
// one-cycle tick on the clk cycle whose closing edge drives PCLK high->low.
module dvp_pclk_gen
    import dvp_pkg::*;
#(
    parameter int CLK_DIV = DVP_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic pclk,
    output logic fall_tick
);

    localparam int DIV_W = clog2_min1(CLK_DIV);

    logic [DIV_W-1:0] div_count;
    logic             wrap;

    assign wrap      = (div_count == DIV_W'(CLK_DIV - 1));
    assign fall_tick = wrap & pclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_count <= '0;
            pclk      <= 1'b0;
        end else if (wrap) begin
            div_count <= '0;
            pclk      <= ~pclk;
        end else begin
            div_count <= div_count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dvp_stream_tx.sv
// DVP transmitter: valid/ready byte stream to PCLK/HS/VS/data framing.
// Optional build macro DVP_TEST_PATTERN_EN adds a per-frame hcount^vcount pattern source.
module dvp_stream_tx
    import dvp_pkg::*;
#(
    parameter int         H_ACTIVE     = DVP_H_ACTIVE,
    parameter int         H_BLANK      = DVP_H_BLANK,
    parameter int         V_ACTIVE     = DVP_V_ACTIVE,
    parameter int         V_BLANK      = DVP_V_BLANK,
    parameter int         CLK_DIV      = DVP_CLK_DIV,
    parameter int         HCOUNT_WIDTH = DVP_HCOUNT_WIDTH,
    parameter int         VCOUNT_WIDTH = DVP_VCOUNT_WIDTH,
    parameter logic [7:0] FILL_BYTE    = DVP_FILL_BYTE
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable_in,
    input  logic [7:0] pixel_data_in,
    input  logic       pixel_valid_in,
`ifdef DVP_TEST_PATTERN_EN
    input  logic       test_pattern_in,
`endif
    output logic       pixel_ready_out,
    output logic       camera_pclk_out,
    output logic       camera_hs_out,
    output logic       camera_vs_out,
    output logic [7:0] camera_data_out,
    output logic       frame_done_out,
    output logic       underflow_out
);

    localparam int BLANK_PERIODS = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int BLANK_W       = clog2_min1(BLANK_PERIODS);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("dvp_stream_tx: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || V_BLANK < 1) begin : g_bad_timing
        $error("dvp_stream_tx: all timing parameters must be at least 1");
    end
    if (H_ACTIVE > (1 << HCOUNT_WIDTH) || H_BLANK > (1 << HCOUNT_WIDTH)) begin : g_bad_hcount
        $error("dvp_stream_tx: HCOUNT_WIDTH too narrow for H_ACTIVE/H_BLANK");
    end
    if (V_ACTIVE > (1 << VCOUNT_WIDTH)) begin : g_bad_vcount
        $error("dvp_stream_tx: VCOUNT_WIDTH too narrow for V_ACTIVE");
    end

    dvp_state_t              state, state_next;
    logic [HCOUNT_WIDTH-1:0] hcount, hcount_next;
    logic [VCOUNT_WIDTH-1:0] vcount, vcount_next;
    logic [BLANK_W-1:0]      blank_count, blank_next;
    logic                    fall_tick;
    logic                    slot;
    logic                    done;
    logic                    pattern_mode;

    dvp_pclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pclk_gen (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .pclk      (camera_pclk_out),
        .fall_tick (fall_tick)
    );

    // Everything advances on fall ticks only; slot marks a byte position in ACTIVE.
    always_comb begin
        state_next  = state;
        hcount_next = hcount;
        vcount_next = vcount;
        blank_next  = blank_count;
        slot        = 1'b0;
        done        = 1'b0;
        if (fall_tick) begin
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        state_next  = VBLANK;
                        hcount_next = '0;
                        vcount_next = '0;
                        blank_next  = '0;
                    end
                end
                VBLANK: begin
                    vcount_next = '0;
                    if (blank_count == BLANK_W'(BLANK_PERIODS - 1)) begin
                        state_next  = ACTIVE;
                        hcount_next = '0;
                        slot        = 1'b1;
                    end else begin
                        blank_next = blank_count + BLANK_W'(1);
                    end
                end
                ACTIVE: begin
                    if (hcount == HCOUNT_WIDTH'(H_ACTIVE - 1)) begin
                        state_next  = HBLANK;
                        hcount_next = '0;
                    end else begin
                        hcount_next = hcount + HCOUNT_WIDTH'(1);
                        slot        = 1'b1;
                    end
                end
                HBLANK: begin
                    if (hcount == HCOUNT_WIDTH'(H_BLANK - 1)) begin
                        hcount_next = '0;
                        if (vcount < VCOUNT_WIDTH'(V_ACTIVE - 1)) begin
                            state_next  = ACTIVE;
                            vcount_next = vcount + VCOUNT_WIDTH'(1);
                            slot        = 1'b1;
                        end else begin
                            state_next  = enable_in ? VBLANK : IDLE;
                            vcount_next = '0;
                            blank_next  = '0;
                            done        = 1'b1;
                        end
                    end else begin
                        hcount_next = hcount + HCOUNT_WIDTH'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            hcount      <= '0;
            vcount      <= '0;
            blank_count <= '0;
        end else begin
            state       <= state_next;
            hcount      <= hcount_next;
            vcount      <= vcount_next;
            blank_count <= blank_next;
        end
    end

`ifdef DVP_TEST_PATTERN_EN
    logic [7:0] pattern_byte;

    assign pattern_byte = 8'(hcount_next) ^ 8'(vcount_next);

    // The source choice is frozen for a whole frame at VBLANK entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pattern_mode <= 1'b0;
        end else if (fall_tick && state_next == VBLANK && state != VBLANK) begin
            pattern_mode <= test_pattern_in;
        end
    end
`else
    assign pattern_mode = 1'b0;
`endif

    assign pixel_ready_out = slot & ~pattern_mode;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            camera_hs_out   <= 1'b0;
            camera_vs_out   <= 1'b0;
            camera_data_out <= FILL_BYTE;
            frame_done_out  <= 1'b0;
            underflow_out   <= 1'b0;
        end else begin
            frame_done_out <= done;
            if (fall_tick) begin
                camera_hs_out   <= (state_next == ACTIVE);
                camera_vs_out   <= (state_next == ACTIVE) || (state_next == HBLANK);
                camera_data_out <= FILL_BYTE;
                if (slot) begin
`ifdef DVP_TEST_PATTERN_EN
                    if (pattern_mode) begin
                        camera_data_out <= pattern_byte;
                    end else if (pixel_valid_in) begin
                        camera_data_out <= pixel_data_in;
                    end
`else
                    if (pixel_valid_in) begin
                        camera_data_out <= pixel_data_in;
                    end
`endif
                end
            end
            if (slot && !pattern_mode && !pixel_valid_in) begin
                underflow_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dvp_stream_tx.sv
// Directed bench for dvp_stream_tx with a small rising-edge DVP receiver model.
// Build with DVP_TEST_PATTERN_EN to also exercise the pattern source.
`timescale 1ns/1ps
module tb_dvp_stream_tx;

    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 2;
    localparam int V_ACTIVE = 2;
    localparam int V_BLANK  = 1;
    localparam int CLK_DIV  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] pixel_data = 8'h00;
    logic       pixel_valid = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
    logic       test_pattern = 1'b0;
`endif
    logic       pixel_ready;
    logic       pclk;
    logic       hs;
    logic       vs;
    logic [7:0] data;
    logic       frame_done;
    logic       underflow;

    dvp_stream_tx #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .pixel_data_in   (pixel_data),
        .pixel_valid_in  (pixel_valid),
`ifdef DVP_TEST_PATTERN_EN
        .test_pattern_in (test_pattern),
`endif
        .pixel_ready_out (pixel_ready),
        .camera_pclk_out (pclk),
        .camera_hs_out   (hs),
        .camera_vs_out   (vs),
        .camera_data_out (data),
        .frame_done_out  (frame_done),
        .underflow_out   (underflow)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic       prev_pclk = 1'b0;
    logic       prev_hs = 1'b0;
    logic       prev_vs = 1'b0;
    logic       prev_ready = 1'b0;
    bit         back_to_back = 1'b0;
    bit         consume_pending = 1'b0;
    logic [7:0] next_byte = 8'h10;
    int         ready_cnt = 0;
    int         drop_target = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         last_vs_cyc = -1;
    int         last_vs_rise = -1;
    int         pclk_rises = 0;
    int         hs_rise[$];
    int         hs_fall[$];
    logic [7:0] rx_q[$];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clk cycle: source update, slot bookkeeping, and receiver sampling.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (consume_pending) next_byte++;
        consume_pending = 1'b0;
        pixel_data      = next_byte;
        pixel_valid     = 1'b1;
        if (pixel_ready) begin
            if (prev_ready) back_to_back = 1'b1;
            pixel_valid     = (ready_cnt != drop_target);
            consume_pending = pixel_valid;
            ready_cnt++;
        end
        prev_ready = pixel_ready;
        if (pclk && !prev_pclk) begin
            pclk_rises++;
            if (hs && vs) rx_q.push_back(data);
        end
        if (hs && !prev_hs) hs_rise.push_back(cyc);
        if (!hs && prev_hs) hs_fall.push_back(cyc);
        if (vs) last_vs_cyc = cyc;
        if (vs && !prev_vs) last_vs_rise = cyc;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_pclk = pclk;
        prev_hs   = hs;
        prev_vs   = vs;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         r;
        int         r2;
        int         snap;
        int         nrises;
        logic [7:0] pclk_pat;
        logic [7:0] exp_f2 [8];
`ifdef DVP_TEST_PATTERN_EN
        int         base;
        int         ready_snap;
        logic [7:0] exp_pat [4];
`endif

        exp_f2 = '{8'h18, 8'h19, 8'h00, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E};

        #2 rst_n = 1'b0;
        repeat (3) step();
        check_output("reset_pclk", pclk, 0);
        check_output("reset_hs", hs, 0);
        check_output("reset_vs", vs, 0);
        check_output("reset_data", data, 8'h00);
        check_output("reset_ready", pixel_ready, 0);
        check_output("reset_done", frame_done, 0);
        check_output("reset_underflow", underflow, 0);

        // Frame 1: continuous valid stream starting at 0x10.
        enable = 1'b1;
        rst_n  = 1'b1;
        r      = cyc;
        pclk_pat = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            pclk_pat = {pclk_pat[6:0], pclk};
        end
        check_output("pclk_waveform", pclk_pat, 8'b0110_0110);

        run_to(r + 80);
        check_output("first_hs_rise", hs_rise[0] - r, 28);
        check_output("hs_high_len", hs_fall[0] - hs_rise[0], 16);
        check_output("line_pitch", hs_rise[1] - hs_rise[0], 24);
        check_output("f1_done_cnt", done_cnt, 1);
        check_output("f1_done_time", done_cyc - r, 76);
        check_output("f1_done_after_active", done_cyc - hs_rise[0], 48);
        check_output("f1_rx_count", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("f1_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
        end
        check_output("f1_ready_cnt", ready_cnt, 8);
        check_output("f1_underflow", underflow, 0);

        // Frame 2: the third slot of line 0 finds no valid byte.
        drop_target = 10;
        run_to(r + 152);
        drop_target = -1;
        check_output("f2_done_cnt", done_cnt, 2);
        check_output("f2_done_time", done_cyc - r, 148);
        check_output("f2_line0_rise", hs_rise[2] - r, 100);
        check_output("f2_line1_rise", hs_rise[3] - r, 124);
        check_output("f2_underflow", underflow, 1);
        check_output("f2_rx_count", rx_q.size(), 16);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("f2_byte%0d", i), rx_q[8 + i], exp_f2[i]);
        end

        // Frame 3: enable drops mid-frame; frame still completes, then IDLE.
        run_to(r + 180);
        check_output("f3_hs_active", hs, 1);
        enable = 1'b0;
        run_to(r + 220);
        snap = pclk_rises;
        run_to(r + 260);
        check_output("f3_done_cnt", done_cnt, 3);
        check_output("f3_done_time", done_cyc - r, 220);
        check_output("f3_last_vs", last_vs_cyc - r, 219);
        check_output("idle_vs", vs, 0);
        check_output("idle_pclk_rises", pclk_rises - snap, 10);
        check_output("f3_rx_count", rx_q.size(), 24);
        check_output("f3_last_byte", rx_q[23], 8'h26);
        check_output("underflow_sticky", underflow, 1);

        // Asynchronous reset in the middle of an active line.
        enable = 1'b1;
        run_to(r + 292);
        check_output("pre_reset_hs", hs, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_pclk", pclk, 0);
        check_output("async_hs", hs, 0);
        check_output("async_vs", vs, 0);
        check_output("async_data", data, 8'h00);
        check_output("async_ready", pixel_ready, 0);
        check_output("async_done", frame_done, 0);
        check_output("async_underflow", underflow, 0);
        step();
        step();
`ifdef DVP_TEST_PATTERN_EN
        test_pattern = 1'b1;
        ready_snap   = ready_cnt;
        base         = rx_q.size();
`endif
        nrises = hs_rise.size();
        rst_n  = 1'b1;
        r2     = cyc;
        run_to(r2 + 32);
        check_output("post_reset_hs_rises", hs_rise.size(), nrises + 1);
        check_output("post_reset_hs_time", hs_rise[nrises] - r2, 28);
        check_output("post_reset_vs_time", last_vs_rise - r2, 28);

`ifdef DVP_TEST_PATTERN_EN
        exp_pat = '{8'h01, 8'h00, 8'h03, 8'h02};
        run_to(r2 + 80);
        check_output("pat_done_time", done_cyc - r2, 76);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("pat_line1_byte%0d", i), rx_q[base + 4 + i], exp_pat[i]);
        end
        check_output("pat_no_ready", ready_cnt, ready_snap);
        check_output("pat_underflow", underflow, 0);
`endif

        check_output("ready_not_back_to_back", back_to_back, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
